// File: rtl/johnson_seq_pkg.sv
// -----------------------------------------------------------------------------
// johnson_seq_pkg
// Shared definitions for the Johnson sequence controller:
//   - FSM state encodings (IDLE, RUN, PAUSE, DONE)
//   - seq_len(width)          : sequence length, 2*width
//   - johnson_next(q,dir,w)   : one Johnson step forward (dir=0) or reverse
//   - johnson_of_phase(p,w)   : the Johnson code sitting at forward index p
// Vectors are carried at MAX_W bits so the helpers serve any legal WIDTH;
// callers slice the low WIDTH bits.
// -----------------------------------------------------------------------------
package johnson_seq_pkg;

   localparam int MAX_W = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int seq_len(input int width);
      return 2 * width;
   endfunction

   // Forward shifts right and feeds ~q[0] into the top stage; reverse shifts
   // left and feeds ~q[top] into bit 0, which retraces the forward sequence.
   function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] q,
                                                    input logic             dir,
                                                    input int               width);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] n;
      logic [3:0]       top;
      mask = MAX_W'((32'd1 << width) - 32'd1);
      top  = 4'(width - 1);
      if (!dir) begin
         n      = q >> 1;
         n[top] = ~q[0];
      end else begin
         n    = (q << 1) & mask;
         n[0] = ~q[top];
      end
      return n;
   endfunction

   // Index p < width: the top p stages are ones. Index p >= width: the ones
   // have drained from the top, leaving (2*width - p) ones at the bottom.
   function automatic logic [MAX_W-1:0] johnson_of_phase(input int p, input int width);
      int v;
      if (p < width) v = ((1 << p) - 1) << (width - p);
      else           v = (1 << (2 * width - p)) - 1;
      return MAX_W'(v);
   endfunction

endpackage

// File: rtl/johnson_core.sv
// -----------------------------------------------------------------------------
// johnson_core
// WIDTH-stage Johnson register plus its forward phase index, updated together.
// Optional feature macro: JOHNSON_SEQ_DECODE_EN (adds phase_oh and forces any
// non-Johnson q back to zero).
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        take one step this edge
//   dir       0 = forward, 1 = reverse
//   clr       return q/phase to zero (wins over en)
//   q         Johnson counter state
//   phase     forward index of q, 0..2*WIDTH-1
//   phase_oh  registered one-hot of phase (JOHNSON_SEQ_DECODE_EN only)
// -----------------------------------------------------------------------------
module johnson_core
   import johnson_seq_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int PH_W  = $clog2(2 * WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               dir,
   input  logic               clr,
   output logic [WIDTH-1:0]   q,
   output logic [PH_W-1:0]    phase
`ifdef JOHNSON_SEQ_DECODE_EN
   ,
   output logic [2*WIDTH-1:0] phase_oh
`endif
);

   localparam int              LEN     = seq_len(WIDTH);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(LEN - 1);

   logic [MAX_W-1:0] next_wide;
   logic [WIDTH-1:0] q_step;
   logic [PH_W-1:0]  phase_step;
   logic             zero_now;

   assign next_wide = johnson_next(MAX_W'(q), dir, WIDTH);
   assign q_step    = next_wide[WIDTH-1:0];

   // NOTE: every always_comb output gets a default on entry so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      phase_step = phase;
      if (!dir) phase_step = (phase == PH_LAST) ? '0 : phase + 1'b1;
      else      phase_step = (phase == '0) ? PH_LAST : phase - 1'b1;
   end

`ifdef JOHNSON_SEQ_DECODE_EN
   // q must always equal the code implied by phase; anything else is an
   // upset and the pair is resynchronised to index 0.
   logic [MAX_W-1:0] q_ref;
   assign q_ref    = johnson_of_phase(int'(phase), WIDTH);
   assign zero_now = clr | (q != q_ref[WIDTH-1:0]);
`else
   assign zero_now = clr;
`endif

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || zero_now) begin
         q     <= '0;
         phase <= '0;
`ifdef JOHNSON_SEQ_DECODE_EN
         phase_oh <= LEN'(1);
`endif
      end else if (en) begin
         q     <= q_step;
         phase <= phase_step;
`ifdef JOHNSON_SEQ_DECODE_EN
         phase_oh <= LEN'(1) << phase_step;
`endif
      end
   end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
// Start/stop/pause sequencer around a WIDTH-bit Johnson counter with direction
// select, programmable step count and a one-cycle done pulse.
// Optional feature macro: JOHNSON_SEQ_DECODE_EN (adds phase_oh output and an
// illegal-state recovery inside the core).
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     begin a run (ignored while busy); latches dir and step_cnt
//   stop      abort a run in RUN/PAUSE; highest priority after rst
//   pause     level hold while running
//   dir       0 = forward, 1 = reverse
//   step_cnt  steps per run, 0 = free-run until stop
//   clr       zero q/phase, honoured only in IDLE or DONE
//   q         Johnson counter state
//   phase     forward index of q
//   busy      high in RUN or PAUSE
//   done      one-cycle pulse at the end of a counted run
//   phase_oh  one-hot phase (JOHNSON_SEQ_DECODE_EN only)
// -----------------------------------------------------------------------------
module johnson_seq_ctrl
   import johnson_seq_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int CNT_W = 8,
   localparam int PH_W  = $clog2(2 * WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               dir,
   input  logic [CNT_W-1:0]   step_cnt,
   input  logic               clr,
   output logic [WIDTH-1:0]   q,
   output logic [PH_W-1:0]    phase,
   output logic               busy,
   output logic               done
`ifdef JOHNSON_SEQ_DECODE_EN
   ,
   output logic [2*WIDTH-1:0] phase_oh
`endif
);

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] remaining, remaining_n;
   logic             dir_lat, dir_lat_n;
   logic             counted, counted_n;
   logic             step_en;
   logic             core_clr;

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      dir_lat_n   = dir_lat;
      counted_n   = counted;
      step_en     = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_n     = ST_RUN;
               dir_lat_n   = dir;
               remaining_n = step_cnt;
               counted_n   = |step_cnt;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_RUN: begin
            // The final step leaves remaining at 0; DONE is entered on the
            // edge after it, without stepping again.
            if (stop)                                state_n = ST_IDLE;
            else if (counted && remaining == '0)     state_n = ST_DONE;
            else if (pause)                          state_n = ST_PAUSE;
            else begin
               step_en = 1'b1;
               if (counted) remaining_n = remaining - 1'b1;
            end
         end
         ST_PAUSE: begin
            if (stop)        state_n = ST_IDLE;
            else if (!pause) state_n = ST_RUN;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         dir_lat   <= 1'b0;
         counted   <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         dir_lat   <= dir_lat_n;
         counted   <= counted_n;
      end
   end

   // clr in the same cycle as start still lands, so the new run starts at 0.
   assign core_clr = clr & ((state == ST_IDLE) | (state == ST_DONE));
   assign busy     = (state == ST_RUN) | (state == ST_PAUSE);
   assign done     = (state == ST_DONE);

   johnson_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (step_en),
      .dir      (dir_lat),
      .clr      (core_clr),
      .q        (q),
      .phase    (phase)
`ifdef JOHNSON_SEQ_DECODE_EN
      ,
      .phase_oh (phase_oh)
`endif
   );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_ctrl
// Directed bench for johnson_seq_ctrl at WIDTH=4, CNT_W=8. Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;
   localparam int PH_W  = $clog2(2 * WIDTH);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             pause = 1'b0;
   logic             dir = 1'b0;
   logic [CNT_W-1:0] step_cnt = '0;
   logic             clr = 1'b0;
   logic [WIDTH-1:0] q;
   logic [PH_W-1:0]  phase;
   logic             busy;
   logic             done;
`ifdef JOHNSON_SEQ_DECODE_EN
   logic [2*WIDTH-1:0] phase_oh;
`endif

   int total = 0;
   int bad   = 0;
   int done_seen = 0;

   // Forward WIDTH=4 sequence; entry i is the code at phase i.
   logic [3:0] fwd [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};

   johnson_seq_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .dir      (dir),
      .step_cnt (step_cnt),
      .clr      (clr),
      .q        (q),
      .phase    (phase),
      .busy     (busy),
      .done     (done)
`ifdef JOHNSON_SEQ_DECODE_EN
      ,
      .phase_oh (phase_oh)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_seen++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [3:0] eq, input int eph,
                             input logic eb, input logic ed);
      check({tag, ".q"},     32'(q),     32'(eq));
      check({tag, ".phase"}, 32'(phase), 32'(eph));
      check({tag, ".busy"},  32'(busy),  32'(eb));
      check({tag, ".done"},  32'(done),  32'(ed));
   endtask

   initial begin
      int d0;

      // Reset for two cycles, then one idle cycle.
      tick();
      tick();
      rst = 1'b0;
      tick();
      expect_all("reset", 4'b0000, 0, 1'b0, 1'b0);
`ifdef JOHNSON_SEQ_DECODE_EN
      check("reset.oh", 32'(phase_oh), 32'h01);
`endif

      // Forward counted run of 8; mid-run dir/step_cnt/start changes ignored.
      dir = 1'b0; step_cnt = 8'd8; start = 1'b1;
      tick();
      expect_all("fwd8.start", 4'b0000, 0, 1'b1, 1'b0);
      start = 1'b0; dir = 1'b1; step_cnt = 8'd2;
      for (int i = 1; i <= 8; i++) begin
         start = (i == 3);
         tick();
         expect_all($sformatf("fwd8.s%0d", i), fwd[i % 8], i % 8, 1'b1, 1'b0);
`ifdef JOHNSON_SEQ_DECODE_EN
         check($sformatf("fwd8.oh%0d", i), 32'(phase_oh), 32'(1) << (i % 8));
`endif
      end
      start = 1'b0;
      tick();
      expect_all("fwd8.done", 4'b0000, 0, 1'b0, 1'b1);
      tick();
      expect_all("fwd8.idle", 4'b0000, 0, 1'b0, 1'b0);

      // Reverse counted run of 3, then clr.
      dir = 1'b1; step_cnt = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         expect_all($sformatf("rev3.s%0d", i), fwd[8 - i], 8 - i, 1'b1, 1'b0);
      end
      tick();
      expect_all("rev3.done", 4'b0111, 5, 1'b0, 1'b1);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      expect_all("rev3.clr", 4'b0000, 0, 1'b0, 1'b0);

      // Free-run forward with a pause at 1110 and a stop at 0011.
      dir = 1'b0; step_cnt = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         expect_all($sformatf("free.s%0d", i), fwd[i], i, 1'b1, 1'b0);
      end
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_all($sformatf("free.p%0d", i), 4'b1110, 3, 1'b1, 1'b0);
      end
      pause = 1'b0;
      tick();
      expect_all("free.resume", 4'b1110, 3, 1'b1, 1'b0);
      for (int i = 4; i <= 6; i++) begin
         tick();
         expect_all($sformatf("free.s%0d", i), fwd[i], i, 1'b1, 1'b0);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      expect_all("free.stop", 4'b0011, 6, 1'b0, 1'b0);
      tick();
      expect_all("free.held", 4'b0011, 6, 1'b0, 1'b0);

      // clr+start together, step_cnt=2, start held through DONE.
      d0 = done_seen;
      clr = 1'b1; start = 1'b1; dir = 1'b0; step_cnt = 8'd2;
      tick();
      clr = 1'b0;
      expect_all("b2b.start", 4'b0000, 0, 1'b1, 1'b0);
      tick();
      expect_all("b2b.r1s1", 4'b1000, 1, 1'b1, 1'b0);
      tick();
      expect_all("b2b.r1s2", 4'b1100, 2, 1'b1, 1'b0);
      tick();
      expect_all("b2b.done1", 4'b1100, 2, 1'b0, 1'b1);
      tick();
      expect_all("b2b.restart", 4'b1100, 2, 1'b1, 1'b0);
      start = 1'b0;
      tick();
      expect_all("b2b.r2s1", 4'b1110, 3, 1'b1, 1'b0);
      tick();
      expect_all("b2b.r2s2", 4'b1111, 4, 1'b1, 1'b0);
      tick();
      expect_all("b2b.done2", 4'b1111, 4, 1'b0, 1'b1);
      tick();
      expect_all("b2b.idle", 4'b1111, 4, 1'b0, 1'b0);
      tick();
      check("b2b.pulses", 32'(done_seen - d0), 32'd2);

      // Reset mid-run at 1111.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      start = 1'b1; step_cnt = 8'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      expect_all("mid.run", 4'b1111, 4, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_all("mid.rst", 4'b0000, 0, 1'b0, 1'b0);
      tick();
      expect_all("mid.idle", 4'b0000, 0, 1'b0, 1'b0);

`ifdef JOHNSON_SEQ_DECODE_EN
      // Upset the register to a non-Johnson code.
      force dut.u_core.q = 4'b0101;
      @(negedge clk);
      release dut.u_core.q;
      tick();
      check("illegal.q",  32'(q),        32'h0);
      check("illegal.ph", 32'(phase),    32'h0);
      check("illegal.oh", 32'(phase_oh), 32'h01);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Controller that sequences a WIDTH-bit Johnson counter. It adds start/stop/pause control, a direction select, a programmable step count with a done pulse, and a phase index.
- Used wherever the lab designs need a self-timed 2*WIDTH-phase sequence. Examples are stepper-motor phase drive and multiphase enables.
- The Johnson register and its phase index live inside this block. Downstream logic consumes q or phase directly.

Parameters:
- WIDTH, 4, number of Johnson stages; sequence length is 2*WIDTH; legal range 2..16.
- CNT_W, 8, width of the programmable step count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a run; sampled each cycle.
- stop  input  1  abort the current run; has priority over all other inputs except rst.
- pause  input  1  level-sensitive hold while RUN.
- dir  input  1  0 = forward, 1 = reverse; latched at start.
- step_cnt  input  CNT_W  steps per run; 0 = free-run until stop; latched at start.
- clr  input  1  return q to all-zero; honoured only in IDLE or DONE.
- q  output  WIDTH  Johnson counter state.
- phase  output  $clog2(2*WIDTH)  index of q in forward sequence, 0..2*WIDTH-1.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse when a counted run completes.

Behaviour:
- Reset: state=IDLE, q=0, phase=0, busy=0, done=0, internal remaining-count=0, latched dir=0.
- Forward step: q_next = {~q[0], q[WIDTH-1:1]}. For WIDTH=4 the sequence is 0000,1000,1100,1110,1111,0111,0011,0001, then back to 0000. phase increments and wraps from 2*WIDTH-1 to 0.
- Reverse step: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]}. This is the exact inverse sequence. phase decrements and wraps from 0 to 2*WIDTH-1.
- q and phase are registered and always updated together. phase always equals the forward index of q.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start=1: latch dir and step_cnt, busy=1, go to RUN. No step occurs in the start cycle.
  - clr=1 without start: q=0, phase=0.
  - clr and start together: clr applies first, and the run begins from 0000.
- RUN:
  - One step per clock.
  - Counted mode: remaining count is decremented each step. The step that takes it from 1 to 0 is the final step. On the next edge the FSM enters DONE with done=1 for exactly that cycle.
  - pause=1: go to PAUSE with no step on that edge.
- PAUSE:
  - q, phase and the remaining count are held.
  - pause=0: return to RUN; stepping resumes on the following edge.
- DONE:
  - busy=0, q is held.
  - Next cycle goes to IDLE. If start=1 in DONE, go directly to RUN (back-to-back run, new values latched).
- stop in RUN or PAUSE: go to IDLE next edge, q/phase held, no done pulse.
- stop in IDLE or DONE: no effect beyond the DONE to IDLE transition.
- start while busy is ignored. dir and step_cnt changes mid-run are ignored.
- Counted run of N steps from start: done asserts N+1 cycles after the start edge when pause is never asserted.
- Free-run (step_cnt=0) never produces done.
- Reset mid-run: everything returns to reset values on the same edge.

Optional Feature:
- Macro: JOHNSON_SEQ_DECODE_EN.
- Defined: adds output phase_oh [2*WIDTH-1:0], a registered one-hot decode of phase. It is 1 at bit 0 after reset and updates in the same cycle as q.
- Also defined: any non-Johnson q value forces q=0 and phase=0 on the next edge. Such a value should be unreachable and is detected by checking q against the decoded phase.
- Undefined: no phase_oh port, no illegal-state check.

Decomposition:
- Package johnson_seq_pkg holds:
  - the FSM state enum (IDLE, RUN, PAUSE, DONE);
  - function johnson_next(q, dir);
  - constant SEQ_LEN = 2*WIDTH as a function of WIDTH.
- One sub-module is natural: johnson_core. It contains the q and phase registers with enable, dir and clr inputs.
- johnson_seq_ctrl owns the FSM and the step counter.

Test Plan:
- rst=1 for 2 cycles, then idle -> q=0000, phase=0, busy=0, done=0.
- start, dir=0, step_cnt=8, WIDTH=4 -> q walks 1000..0001 then 0000, phase 1..7 then 0. done pulses once 9 cycles after start, then busy=0.
- start, dir=1, step_cnt=3 from 0000 -> q=0001, 0011, 0111, phase=7, 6, 5, then done. Then clr -> q=0000, phase=0.
- Free-run dir=0, pause=1 at q=1110 for 5 cycles, then release, then stop at q=0011 -> q frozen at 1110 during pause. The sequence resumes with 1111. Final q=0011, no done.
- Step_cnt=2 run with start held high through DONE -> second run begins from the DONE cycle with no IDLE cycle. Exactly two done pulses.
- rst asserted mid-run at q=1111 -> next edge q=0000, IDLE. With JOHNSON_SEQ_DECODE_EN, force q=0101 -> next edge q=0000, phase_oh=00000001.
